// File: rtl/tcb_lib_sram_pkg.sv
// Shared types and helpers for the TCB single-port SRAM read-modify-write controller.
package tcb_lib_sram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    // Byte-lane merge: lanes with sel set come from a, the rest from b.
    function automatic logic [31:0] merge_lanes(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                r[8*i +: 8] = a[8*i +: 8];
            end else begin
                r[8*i +: 8] = b[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Window check done in 33 bits so BASE + size cannot wrap.
    function automatic logic addr_hit(
        input logic [31:0] adr,
        input logic [31:0] base,
        input int unsigned mem_aw
    );
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, adr};
        lo = {1'b0, base};
        hi = lo + (33'd4 << mem_aw);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/tcb_lib_sram_rmw.sv
// TCB byte-enable subordinate driving a word-write-only SRAM; partial stores
// become a read followed by a merged write one cycle later.
module tcb_lib_sram_rmw
    import tcb_lib_sram_pkg::*;
#(
    parameter int unsigned       ADR_W  = 32,
    parameter int unsigned       DAT_W  = 32,
    parameter int unsigned       MEM_AW = 20,
    parameter logic [ADR_W-1:0]  BASE   = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tcb_vld,
    input  logic                tcb_wen,
    input  logic                tcb_ren,
    input  logic [ADR_W-1:0]    tcb_adr,
    input  logic [DAT_W/8-1:0]  tcb_ben,
    input  logic [DAT_W-1:0]    tcb_wdt,
    output logic                tcb_rdy,
    output logic [DAT_W-1:0]    tcb_rdt,
    output logic                tcb_err,
    output logic                sram_cen,
    output logic                sram_wen,
    output logic [MEM_AW-1:0]   sram_adr,
    output logic [DAT_W-1:0]    sram_wdt,
    input  logic [DAT_W-1:0]    sram_rdt
);

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   adr_q, adr_d;
    logic [3:0]          ben_q, ben_d;
    logic [31:0]         wdt_q, wdt_d;
    logic                rsp_rd_q, rsp_rd_d;
    logic                rsp_err_q, rsp_err_d;

    logic                trn_s;
    logic                hit_s;
    logic                cen_s;
    logic                wen_s;
    logic [MEM_AW-1:0]   adr_s;
    logic [31:0]         wdt_s;

    assign tcb_rdy = (state_q == ST_IDLE) & rst_n;
    assign trn_s   = tcb_vld & tcb_rdy;
    assign hit_s   = addr_hit(32'(tcb_adr), 32'(BASE), MEM_AW);

    // Next-state, SRAM command and response-pipeline decode.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        ben_d     = ben_q;
        wdt_d     = wdt_q;
        rsp_rd_d  = 1'b0;
        rsp_err_d = 1'b0;
        cen_s     = 1'b0;
        wen_s     = 1'b0;
        adr_s     = tcb_adr[MEM_AW+1:2];
        wdt_s     = tcb_wdt;
        case (state_q)
            ST_IDLE: begin
                if (!trn_s) begin
                    state_d = ST_IDLE;
                end else if (!hit_s) begin
                    rsp_err_d = tcb_wen | tcb_ren;
                end else if (tcb_wen) begin
                    if (tcb_ben == 4'hF) begin
                        cen_s = 1'b1;
                        wen_s = 1'b1;
                    end else if (tcb_ben == 4'h0) begin
                        cen_s = 1'b0;
                    end else begin
                        // Fetch the old word now; merge and write it back next cycle.
                        cen_s   = 1'b1;
                        adr_d   = tcb_adr[MEM_AW+1:2];
                        ben_d   = tcb_ben;
                        wdt_d   = tcb_wdt;
                        state_d = ST_RMW;
                    end
                end else if (tcb_ren) begin
                    cen_s    = 1'b1;
                    ben_d    = tcb_ben;
                    rsp_rd_d = 1'b1;
                end else begin
                    rsp_err_d = 1'b0;
                end
            end
            ST_RMW: begin
                cen_s   = 1'b1;
                wen_s   = 1'b1;
                adr_s   = adr_q;
                wdt_s   = merge_lanes(wdt_q, sram_rdt, ben_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, saved write request and response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            ben_q     <= 4'h0;
            wdt_q     <= 32'h0;
            rsp_rd_q  <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            ben_q     <= ben_d;
            wdt_q     <= wdt_d;
            rsp_rd_q  <= rsp_rd_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Reset gates the chip enable so an in-flight RMW write never lands.
    assign sram_cen = cen_s & rst_n;
    assign sram_wen = wen_s;
    assign sram_adr = adr_s;
    assign sram_wdt = wdt_s;
    assign tcb_rdt  = rsp_rd_q ? merge_lanes(sram_rdt, 32'h0, ben_q) : 32'h0;
    assign tcb_err  = rsp_err_q;

endmodule

// File: tb/tb_tcb_lib_sram_rmw.sv
// Directed self-checking bench for tcb_lib_sram_rmw with a small behavioural SRAM.
module tb_tcb_lib_sram_rmw;

    logic        clk;
    logic        rst_n;
    logic        tcb_vld;
    logic        tcb_wen;
    logic        tcb_ren;
    logic [31:0] tcb_adr;
    logic [3:0]  tcb_ben;
    logic [31:0] tcb_wdt;
    logic        tcb_rdy;
    logic [31:0] tcb_rdt;
    logic        tcb_err;
    logic        sram_cen;
    logic        sram_wen;
    logic [19:0] sram_adr;
    logic [31:0] sram_wdt;
    logic [31:0] sram_rdt;

    logic [31:0] mem [0:255];
    int          pass_cnt;
    int          tot_cnt;
    int          cen_cnt;

    tcb_lib_sram_rmw dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tcb_vld  (tcb_vld),
        .tcb_wen  (tcb_wen),
        .tcb_ren  (tcb_ren),
        .tcb_adr  (tcb_adr),
        .tcb_ben  (tcb_ben),
        .tcb_wdt  (tcb_wdt),
        .tcb_rdy  (tcb_rdy),
        .tcb_rdt  (tcb_rdt),
        .tcb_err  (tcb_err),
        .sram_cen (sram_cen),
        .sram_wen (sram_wen),
        .sram_adr (sram_adr),
        .sram_wdt (sram_wdt),
        .sram_rdt (sram_rdt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_cen) begin
            cen_cnt <= cen_cnt + 1;
            if (sram_wen) mem[sram_adr[7:0]] <= sram_wdt;
            else          sram_rdt <= mem[sram_adr[7:0]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic w, input logic r, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        tcb_vld = 1'b1;
        tcb_wen = w;
        tcb_ren = r;
        tcb_adr = a;
        tcb_ben = b;
        tcb_wdt = d;
    endtask

    task automatic idle_req();
        tcb_vld = 1'b0;
        tcb_wen = 1'b0;
        tcb_ren = 1'b0;
    endtask

    task automatic test_reset();
        set_req(1'b0, 1'b1, 32'h8000_0010, 4'hF, 32'h0);
        tick();
        tot_cnt++; if (tcb_rdy !== 1'b0) $display("FAIL rst_rdy got=%b exp=0", tcb_rdy); else pass_cnt++;
        tot_cnt++; if (sram_cen !== 1'b0) $display("FAIL rst_cen got=%b exp=0", sram_cen); else pass_cnt++;
        tot_cnt++; if (tcb_rdt !== 32'h0) $display("FAIL rst_rdt got=%h exp=0", tcb_rdt); else pass_cnt++;
        tot_cnt++; if (tcb_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", tcb_err); else pass_cnt++;
        idle_req();
        rst_n = 1'b1;
        #1;
        tot_cnt++; if (tcb_rdy !== 1'b1) $display("FAIL rst_rel_rdy got=%b exp=1", tcb_rdy); else pass_cnt++;
        tick();
    endtask

    task automatic test_full_write_read();
        set_req(1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
        #1;
        tot_cnt++; if ({tcb_rdy, sram_cen, sram_wen} !== 3'b111) $display("FAIL fw_cmd got=%b exp=111", {tcb_rdy, sram_cen, sram_wen}); else pass_cnt++;
        tot_cnt++; if (sram_adr !== 20'h4 || sram_wdt !== 32'hDEAD_BEEF) $display("FAIL fw_adr_wdt got=%h/%h exp=4/deadbeef", sram_adr, sram_wdt); else pass_cnt++;
        tick();
        set_req(1'b0, 1'b1, 32'h8000_0010, 4'hF, 32'h0);
        #1;
        tot_cnt++; if (tcb_rdy !== 1'b1) $display("FAIL fw_b2b_rdy got=%b exp=1", tcb_rdy); else pass_cnt++;
        tot_cnt++; if (tcb_err !== 1'b0 || tcb_rdt !== 32'h0) $display("FAIL fw_rsp got=%b/%h exp=0/0", tcb_err, tcb_rdt); else pass_cnt++;
        tick();
        idle_req();
        tot_cnt++; if (tcb_rdt !== 32'hDEAD_BEEF || tcb_err !== 1'b0) $display("FAIL fw_read got=%h/%b exp=deadbeef/0", tcb_rdt, tcb_err); else pass_cnt++;
        tick();
    endtask

    task automatic test_partial_write();
        set_req(1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h1122_3344);
        tick();
        set_req(1'b1, 1'b0, 32'h8000_0020, 4'b0010, 32'h0000_AA00);
        #1;
        tot_cnt++; if ({tcb_rdy, sram_cen, sram_wen} !== 3'b110) $display("FAIL pw_rd_cmd got=%b exp=110", {tcb_rdy, sram_cen, sram_wen}); else pass_cnt++;
        tick();
        idle_req();
        tot_cnt++; if ({tcb_rdy, sram_cen, sram_wen} !== 3'b011) $display("FAIL pw_rmw_cmd got=%b exp=011", {tcb_rdy, sram_cen, sram_wen}); else pass_cnt++;
        tot_cnt++; if (sram_adr !== 20'h8 || sram_wdt !== 32'h1122_AA44) $display("FAIL pw_merge got=%h/%h exp=8/1122aa44", sram_adr, sram_wdt); else pass_cnt++;
        tot_cnt++; if (tcb_err !== 1'b0 || tcb_rdt !== 32'h0) $display("FAIL pw_rsp got=%b/%h exp=0/0", tcb_err, tcb_rdt); else pass_cnt++;
        tick();
        tot_cnt++; if (tcb_rdy !== 1'b1) $display("FAIL pw_rdy_back got=%b exp=1", tcb_rdy); else pass_cnt++;
        set_req(1'b0, 1'b1, 32'h8000_0020, 4'hF, 32'h0);
        tick();
        set_req(1'b0, 1'b1, 32'h8000_0020, 4'b1100, 32'h0);
        #1;
        tot_cnt++; if (tcb_rdt !== 32'h1122_AA44) $display("FAIL pw_read got=%h exp=1122aa44", tcb_rdt); else pass_cnt++;
        tick();
        idle_req();
        tot_cnt++; if (tcb_rdt !== 32'h1122_0000) $display("FAIL ben_read got=%h exp=11220000", tcb_rdt); else pass_cnt++;
        tick();
    endtask

    task automatic test_miss();
        cen_cnt = 0;
        set_req(1'b0, 1'b1, 32'h7FFF_FFFC, 4'hF, 32'h0);
        #1;
        tot_cnt++; if (sram_cen !== 1'b0) $display("FAIL miss_lo_cen got=%b exp=0", sram_cen); else pass_cnt++;
        tick();
        set_req(1'b1, 1'b0, 32'h8040_0000, 4'hF, 32'h1234_5678);
        #1;
        tot_cnt++; if (tcb_err !== 1'b1 || tcb_rdt !== 32'h0) $display("FAIL miss_lo_rsp got=%b/%h exp=1/0", tcb_err, tcb_rdt); else pass_cnt++;
        tick();
        idle_req();
        tot_cnt++; if (tcb_err !== 1'b1 || tcb_rdt !== 32'h0) $display("FAIL miss_hi_rsp got=%b/%h exp=1/0", tcb_err, tcb_rdt); else pass_cnt++;
        tot_cnt++; if (cen_cnt !== 0) $display("FAIL miss_cen_cnt got=%0d exp=0", cen_cnt); else pass_cnt++;
        tick();
        tot_cnt++; if (tcb_err !== 1'b0) $display("FAIL miss_err_clear got=%b exp=0", tcb_err); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        set_req(1'b1, 1'b0, 32'h8000_0020, 4'b1000, 32'h5500_0000);
        tick();
        set_req(1'b0, 1'b1, 32'h8000_0020, 4'hF, 32'h0);
        #1;
        tot_cnt++; if (tcb_rdy !== 1'b0 || sram_wen !== 1'b1) $display("FAIL held_rmw got=%b/%b exp=0/1", tcb_rdy, sram_wen); else pass_cnt++;
        tick();
        tot_cnt++; if ({tcb_rdy, sram_cen, sram_wen} !== 3'b110) $display("FAIL held_accept got=%b exp=110", {tcb_rdy, sram_cen, sram_wen}); else pass_cnt++;
        tick();
        idle_req();
        tot_cnt++; if (tcb_rdt !== 32'h5522_AA44) $display("FAIL held_read got=%h exp=5522aa44", tcb_rdt); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_rmw();
        set_req(1'b1, 1'b0, 32'h8000_0020, 4'b0001, 32'h0000_00FF);
        tick();
        idle_req();
        tot_cnt++; if (sram_cen !== 1'b1 || sram_wen !== 1'b1) $display("FAIL rrmw_pre got=%b/%b exp=1/1", sram_cen, sram_wen); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        tot_cnt++; if (sram_cen !== 1'b0 || tcb_rdy !== 1'b0) $display("FAIL rrmw_gate got=%b/%b exp=0/0", sram_cen, tcb_rdy); else pass_cnt++;
        tick();
        tot_cnt++; if (tcb_rdt !== 32'h0 || tcb_err !== 1'b0) $display("FAIL rrmw_rsp got=%h/%b exp=0/0", tcb_rdt, tcb_err); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        tot_cnt++; if (tcb_rdy !== 1'b1) $display("FAIL rrmw_rel_rdy got=%b exp=1", tcb_rdy); else pass_cnt++;
        set_req(1'b0, 1'b1, 32'h8000_0020, 4'hF, 32'h0);
        tick();
        idle_req();
        tot_cnt++; if (tcb_rdt !== 32'h5522_AA44) $display("FAIL rrmw_word got=%h exp=5522aa44", tcb_rdt); else pass_cnt++;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        pass_cnt = 0;
        tot_cnt  = 0;
        cen_cnt  = 0;
        sram_rdt = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        idle_req();
        tcb_adr = 32'h0;
        tcb_ben = 4'h0;
        tcb_wdt = 32'h0;
        tick();
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_miss();
        test_back_to_back();
        test_reset_mid_rmw();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
